// File: rtl/display_page_controller_if.sv
// Interface between display_page_controller and the board.
// Carries the raw buttons and the halt flag in, and the page-select outputs out.
//
// Signalling: there is no valid/ready handshake. The button inputs are raw
// levels, active-low and asynchronous to the clock. cpu_halt is an active-high
// level that is synchronous to the clock. page and auto_mode are registered
// levels. page_changed is a registered one-cycle pulse. dbg_state mirrors the
// mode FSM state: 0 = MANUAL, 1 = AUTO.
interface display_page_controller_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_mode;
    logic       cpu_halt;
    logic [3:0] page;
    logic       auto_mode;
    logic       page_changed;
    logic       dbg_state;

    modport master (
        output btn_next, btn_prev, btn_mode, cpu_halt,
        input  page, auto_mode, page_changed, dbg_state
    );

    modport slave (
        input  btn_next, btn_prev, btn_mode, cpu_halt,
        output page, auto_mode, page_changed, dbg_state
    );
endinterface

// File: rtl/display_page_controller.sv
// Debug display page selector.
// Debounces the next/prev/mode buttons and can auto-scan through the pages.
// When the CPU halts, it forces the IR/PC page (page 0) and drops back to
// manual mode.
module display_page_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_PERIOD     = 64,
    parameter int PAGES           = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    display_page_controller_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [3:0]    PAGE_LAST  = 4'(PAGES - 1);

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } state_t;

    // Button lanes: bit 0 = next, bit 1 = prev, bit 2 = mode.
    logic [2:0]    raw;
    logic [2:0]    sync1, sync2, acc, acc_prev, press;
    logic [DW-1:0] cnt [3];

    logic          halt_d, halt_rise;

    state_t        state_q, state_n;
    logic [3:0]    page_q, page_n;
    logic [PW-1:0] presc_q, presc_n;
    logic          changed_q;

    logic [3:0]    page_inc, page_dec;
    logic          step_next, step_prev, both, mode_ev, tick;

    assign raw = {bus.btn_mode, bus.btn_prev, bus.btn_next};

    // Synchronise, debounce and edge-detect each button.
    // A press event is issued one cycle after the accepted level falls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1    <= '1;
            sync2    <= '1;
            acc      <= '1;
            acc_prev <= '1;
            press    <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            acc_prev <= acc;
            press    <= acc_prev & ~acc;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    acc[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Register the halt history and the registered halt rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_d    <= 1'b0;
            halt_rise <= 1'b0;
        end else begin
            halt_d    <= bus.cpu_halt;
            halt_rise <= bus.cpu_halt & ~halt_d;
        end
    end

    // Next state, next page and prescaler, applied in priority order:
    // halt edge, then simultaneous next+prev (ignored), then a single step,
    // then the auto tick.
    always_comb begin
        state_n   = state_q;
        page_n    = page_q;
        presc_n   = presc_q;
        page_inc  = (page_q == PAGE_LAST) ? 4'd0 : page_q + 4'd1;
        page_dec  = (page_q == 4'd0) ? PAGE_LAST : page_q - 4'd1;
        step_next = press[0] & ~press[1];
        step_prev = press[1] & ~press[0];
        both      = press[0] & press[1];
        mode_ev   = press[2] & ~bus.cpu_halt;
        tick      = (state_q == S_AUTO) && (presc_q == PRESC_LAST);

        if (halt_rise) begin
            page_n  = 4'd0;
            state_n = S_MANUAL;
            presc_n = '0;
        end else begin
            if (mode_ev) begin
                state_n = (state_q == S_AUTO) ? S_MANUAL : S_AUTO;
            end
            if (step_next) begin
                page_n = page_inc;
            end else if (step_prev) begin
                page_n = page_dec;
            end else if (tick && !both && !mode_ev) begin
                page_n = page_inc;
            end
            if (mode_ev || state_q != S_AUTO) begin
                presc_n = '0;
            end else if (step_next || step_prev || tick) begin
                presc_n = '0;
            end else begin
                presc_n = presc_q + 1'b1;
            end
        end
    end

    // State, page, prescaler and change-pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_MANUAL;
            page_q    <= 4'd0;
            presc_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            page_q    <= page_n;
            presc_q   <= presc_n;
            changed_q <= (page_n != page_q);
        end
    end

    assign bus.page         = page_q;
    assign bus.auto_mode    = (state_q == S_AUTO);
    assign bus.page_changed = changed_q;
    assign bus.dbg_state    = state_q;
endmodule
